branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control-flow redirects in the pipelined RV32I core. It samples the resolved PC source from the branch condition generator in EX, registers the redirect target, and drives PC-select, flush and kill strobes to the front end. Registering the redirect cuts the comparator-to-PC-mux timing path at the cost of one extra squashed slot. It also holds the redirect across memory stalls.

## Interface
- Parameters
- XLEN, 32, PC/target width
- Ports
- CLK  in  1  core clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- EX_VALID  in  1  EX stage holds a live (non-bubble) instruction
- EX_IS_BRANCH  in  1  EX instruction is B-type (used for statistics only)
- EX_PC_SOURCE  in  2  resolved source from BCG: 00 seq, 01 JALR, 10 branch, 11 JAL
- EX_TARGET  in  XLEN  target already selected for EX_PC_SOURCE
- MEM_STALL  in  1  pipeline frozen this cycle; no stage advances
- PC_REDIRECT  out  1  PC register loads PC_TARGET on next advancing edge
- PC_TARGET  out  XLEN  registered redirect target
- PC_SEL  out  2  registered copy of captured EX_PC_SOURCE, 00 when idle
- FLUSH_IF_ID  out  1  IF/ID register loads a bubble
- FLUSH_ID_EX  out  1  ID/EX register loads a bubble
- KILL_EX  out  1  EX→MEM transfer is marked invalid
- STAT_BRANCHES, STAT_TAKEN, STAT_JUMPS  out  32 each  statistics (see Configuration)

## Operation
- Two states: IDLE, REDIRECT.
- Capture condition (cycle T): state==IDLE && EX_VALID && EX_PC_SOURCE!=00 && !MEM_STALL.
- IDLE → REDIRECT on capture. Register PC_TARGET←EX_TARGET, PC_SEL←EX_PC_SOURCE.
- REDIRECT: PC_REDIRECT, FLUSH_IF_ID, FLUSH_ID_EX, KILL_EX all 1.
- In REDIRECT, EX_* inputs are ignored; EX holds the wrong-path instruction.
- REDIRECT → IDLE on the first cycle with MEM_STALL=0. Remains in REDIRECT with all outputs and PC_TARGET held while MEM_STALL=1.
- Capture never occurs while MEM_STALL=1. The taken instruction stays in EX and is captured in the first non-stalled cycle.
- In IDLE, all strobes are 0 and PC_SEL=00. PC_TARGET keeps its last value.
- Strobes are Moore outputs decoded from state; no combinational path from EX_* to outputs.

## Timing
- Reset values: state IDLE; PC_REDIRECT, FLUSH_IF_ID, FLUSH_ID_EX, KILL_EX = 0; PC_SEL=00; PC_TARGET=0; stats=0.
- Latency: taken at T (no stall) → strobes high in T+1 → PC loads target at edge ending T+1, so the target is fetched in T+2.
- Penalty: 3 squashed slots (IF, ID, EX contents at T+1).
- Back-to-back taken instructions: the second is necessarily wrong-path and is ignored in REDIRECT.
- RST asserted mid-REDIRECT: outputs drop asynchronously and the redirect is lost. The core reset PC governs.

## Configuration
- BRANCH_STATS_EN defined: three 32-bit saturating counters, each incremented on a cycle where EX_VALID && !MEM_STALL && state==IDLE:
  - STAT_BRANCHES: EX_IS_BRANCH.
  - STAT_TAKEN: EX_IS_BRANCH && EX_PC_SOURCE==10.
  - STAT_JUMPS: EX_PC_SOURCE ∈ {01,11}.
  - Saturation holds each counter at 0xFFFFFFFF.
- BRANCH_STATS_EN undefined: ports remain, tied to 0, no counter flops.

## Structure
- Shared package (core_pkg): pc_src_t enum (PC_SEQ=2'b00, PC_JALR=2'b01, PC_BRANCH=2'b10, PC_JAL=2'b11) and redir_state_t enum {IDLE, REDIRECT}.
- One sub-module: sat_counter (parameterised width, inc enable, async active-high reset), instantiated three times under BRANCH_STATS_EN.

## Test plan
- Reset check: RST=1 then released → all outputs 0, PC_SEL=00, PC_TARGET=0, stats 0.
- Taken branch: EX_VALID=1, PC_SOURCE=10, TARGET=0x0000_0100 at T → T+1 strobes all 1, PC_TARGET=0x100, PC_SEL=10. T+2 all strobes 0.
- Stall before capture: taken JAL (11, 0x200) with MEM_STALL=1 for 3 cycles → no strobes. Capture on the first unstalled cycle, strobes one cycle later.
- Stall during REDIRECT: MEM_STALL=1 for 2 cycles in T+1 → strobes and 0x100 held 3 cycles, then IDLE.
- Wrong-path ignored: PC_SOURCE=01 with TARGET=0x300 presented in T+1 → PC_TARGET stays 0x100, no second redirect.
- Stats (BRANCH_STATS_EN): 4 branches (2 taken), 1 JALR → STAT_BRANCHES=4, STAT_TAKEN=2, STAT_JUMPS=1. Async RST mid-REDIRECT → strobes 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the redirect controller: resolved PC source encoding and
// the redirect FSM state.
package core_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JALR   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JAL    = 2'b11
    } pc_src_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Registered control-flow redirect sequencer: captures a taken EX transfer and
// drives PC-select/flush/kill strobes one cycle later. Statistics counters are
// built only when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_branch,
    input  logic [1:0]      i_ex_pc_source,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_mem_stall,
    output logic            o_pc_redirect,
    output logic [XLEN-1:0] o_pc_target,
    output logic [1:0]      o_pc_sel,
    output logic            o_flush_if_id,
    output logic            o_flush_id_ex,
    output logic            o_kill_ex,
    output logic [31:0]     o_stat_branches,
    output logic [31:0]     o_stat_taken,
    output logic [31:0]     o_stat_jumps
);

    redir_state_t    r_state;
    redir_state_t    w_state_next;
    logic [XLEN-1:0] r_pc_target;
    pc_src_t         r_pc_sel;
    logic            w_capture;
    logic            w_redirect;

    assign w_capture = (r_state == IDLE) && i_ex_valid &&
                       (i_ex_pc_source != PC_SEQ) && !i_mem_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_capture)    w_state_next = REDIRECT;
            REDIRECT: if (!i_mem_stall) w_state_next = IDLE;
        endcase
    end

    // PC_SEL returns to PC_SEQ as the redirect retires; the target is kept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc_target <= '0;
            r_pc_sel    <= PC_SEQ;
        end else if (w_capture) begin
            r_pc_target <= i_ex_target;
            r_pc_sel    <= pc_src_t'(i_ex_pc_source);
        end else if ((r_state == REDIRECT) && !i_mem_stall) begin
            r_pc_sel    <= PC_SEQ;
        end
    end

    assign w_redirect    = (r_state == REDIRECT);
    assign o_pc_redirect = w_redirect;
    assign o_flush_if_id = w_redirect;
    assign o_flush_id_ex = w_redirect;
    assign o_kill_ex     = w_redirect;
    assign o_pc_target   = r_pc_target;
    assign o_pc_sel      = r_pc_sel;

`ifdef BRANCH_STATS_EN
    logic w_stat_en;
    assign w_stat_en = (r_state == IDLE) && i_ex_valid && !i_mem_stall;

    sat_counter #(.WIDTH(32)) u_stat_branches (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_stat_en && i_ex_is_branch),
        .o_count (o_stat_branches)
    );

    sat_counter #(.WIDTH(32)) u_stat_taken (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_stat_en && i_ex_is_branch && (i_ex_pc_source == PC_BRANCH)),
        .o_count (o_stat_taken)
    );

    sat_counter #(.WIDTH(32)) u_stat_jumps (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_stat_en && ((i_ex_pc_source == PC_JALR) || (i_ex_pc_source == PC_JAL))),
        .o_count (o_stat_jumps)
    );
`else
    logic w_unused;
    assign w_unused        = i_ex_is_branch;
    assign o_stat_branches = '0;
    assign o_stat_taken    = '0;
    assign o_stat_jumps    = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a behavioural model pushes the
// expected post-edge outputs for each driven cycle; they are popped after the edge.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;

    typedef struct {
        logic            redir;
        logic [XLEN-1:0] target;
        logic [1:0]      sel;
        logic [31:0]     br;
        logic [31:0]     tk;
        logic [31:0]     jp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_valid = 1'b0;
    logic            ex_is_branch = 1'b0;
    logic [1:0]      ex_pc_source = 2'b00;
    logic [XLEN-1:0] ex_target = '0;
    logic            mem_stall = 1'b0;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic [1:0]      pc_sel;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            kill_ex;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_taken;
    logic [31:0]     stat_jumps;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];

    logic            m_redir  = 1'b0;
    logic [XLEN-1:0] m_target = '0;
    logic [1:0]      m_sel    = 2'b00;
    logic [31:0]     m_br     = '0;
    logic [31:0]     m_tk     = '0;
    logic [31:0]     m_jp     = '0;

    branch_redirect_ctrl #(.XLEN(XLEN)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ex_valid      (ex_valid),
        .i_ex_is_branch  (ex_is_branch),
        .i_ex_pc_source  (ex_pc_source),
        .i_ex_target     (ex_target),
        .i_mem_stall     (mem_stall),
        .o_pc_redirect   (pc_redirect),
        .o_pc_target     (pc_target),
        .o_pc_sel        (pc_sel),
        .o_flush_if_id   (flush_if_id),
        .o_flush_id_ex   (flush_id_ex),
        .o_kill_ex       (kill_ex),
        .o_stat_branches (stat_branches),
        .o_stat_taken    (stat_taken),
        .o_stat_jumps    (stat_jumps)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_val("pc_redirect", {31'd0, pc_redirect}, {31'd0, e.redir});
        check_val("flush_if_id", {31'd0, flush_if_id}, {31'd0, e.redir});
        check_val("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.redir});
        check_val("kill_ex",     {31'd0, kill_ex},     {31'd0, e.redir});
        check_val("pc_target",   pc_target,            e.target);
        check_val("pc_sel",      {30'd0, pc_sel},      {30'd0, e.sel});
        check_val("stat_branches", stat_branches, e.br);
        check_val("stat_taken",    stat_taken,    e.tk);
        check_val("stat_jumps",    stat_jumps,    e.jp);
    endtask

    // Drive one cycle of EX inputs, predict the post-edge outputs, compare after the edge.
    task automatic cyc(input logic v, input logic isbr, input logic [1:0] src,
                       input logic [XLEN-1:0] tgt, input logic stall);
        exp_t e;
        ex_valid     = v;
        ex_is_branch = isbr;
        ex_pc_source = src;
        ex_target    = tgt;
        mem_stall    = stall;
`ifdef BRANCH_STATS_EN
        if (!m_redir && v && !stall) begin
            if (isbr && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (isbr && src == 2'b10 && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
            if ((src == 2'b01 || src == 2'b11) && m_jp != 32'hFFFF_FFFF) m_jp = m_jp + 1;
        end
`endif
        if (m_redir) begin
            if (!stall) begin
                m_redir = 1'b0;
                m_sel   = 2'b00;
            end
        end else if (v && src != 2'b00 && !stall) begin
            m_redir  = 1'b1;
            m_target = tgt;
            m_sel    = src;
        end
        e = '{redir: m_redir, target: m_target, sel: m_sel, br: m_br, tk: m_tk, jp: m_jp};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            check_outputs(exp_q.pop_front());
        end
    endtask

    initial begin
        exp_t r0;
        r0 = '{redir: 1'b0, target: '0, sel: 2'b00, br: '0, tk: '0, jp: '0};

        repeat (2) @(posedge clk);
        #1;
        check_outputs(r0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(r0);

        // taken branch, then wrong-path JALR presented during REDIRECT
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0100, 1'b0);
        cyc(1'b1, 1'b0, 2'b01, 32'h0000_0300, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);

        // JAL held in EX by a 3-cycle stall before capture
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'b11, 32'h0000_0200, 1'b1);
        cyc(1'b1, 1'b0, 2'b11, 32'h0000_0200, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);

        // stall during REDIRECT holds strobes and target
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0100, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0400, 1'b1);
        cyc(1'b1, 1'b0, 2'b11, 32'h0000_0500, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);

        // statistics mix: not-taken/taken branches, JALR, bubbles and stalled slots
        cyc(1'b1, 1'b1, 2'b00, 32'h0000_0010, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0600, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 32'h0000_0700, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 32'h0000_0020, 1'b1);
        cyc(1'b1, 1'b1, 2'b00, 32'h0000_0020, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0800, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        cyc(1'b1, 1'b0, 2'b01, 32'h0000_0900, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 32'hFFFF) << 2), ($urandom_range(0, 3) == 0));
        end
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);

        // async reset in the middle of a redirect
        cyc(1'b1, 1'b0, 2'b11, 32'h0000_0A00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_redirect", {31'd0, pc_redirect}, 32'd0);
        check_val("async_rst_kill",     {31'd0, kill_ex},     32'd0);
        check_val("async_rst_target",   pc_target,            32'd0);
        check_val("async_rst_sel",      {30'd0, pc_sel},      32'd0);
        check_val("async_rst_branches", stat_branches,        32'd0);
        m_redir  = 1'b0;
        m_target = '0;
        m_sel    = 2'b00;
        m_br     = '0;
        m_tk     = '0;
        m_jp     = '0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 32'h0000_0B00, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
